// File: rtl/imm_pkg.sv
// Shared types and widths for the immediate packer (imm_pack) and the
// immediate extension unit (ext_module). The imm_ctrl encoding is common to
// both, so the expander's IMM_HI19 support comes from this same package.
package imm_pkg;

    localparam int SHORT_W = 13;  // short immediate, ctrl 00 / 01
    localparam int LONG_W  = 26;  // long immediate, ctrl 10
    localparam int HI_W    = 19;  // upper field of a split constant, ctrl 11

    // How ext_module expands an immediate field back to 32 bits.
    typedef enum logic [1:0] {
        IMM_Z13  = 2'b00,  // zero-extend imm[12:0]
        IMM_S13  = 2'b01,  // sign-extend imm[12:0]
        IMM_L26  = 2'b10,  // zero-extend imm[25:0]
        IMM_HI19 = 2'b11   // imm[18:0] << 13
    } imm_ctrl_t;

    // Output sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,  // no beat presented
        ST_ONE  = 2'b01,  // single-field beat, last
        ST_HI   = 2'b10,  // upper 19 bits of a split constant
        ST_LO   = 2'b11   // lower 13 bits of a split constant, last
    } pack_state_t;

    // Result of classifying one constant. For a split constant, imm/ctrl
    // describe the HI beat; the LO beat is rebuilt from the low 13 bits.
    typedef struct packed {
        imm_ctrl_t         ctrl;
        logic              split;
        logic [LONG_W-1:0] imm;
    } imm_class_t;

endpackage

// File: rtl/imm_classify.sv
// Purely combinational classifier: picks the smallest immediate field that
// ext_module expands back to exactly the given 32-bit value. Priority is
// Z13, then S13, then L26, otherwise the value must be split in two beats.
module imm_classify
    import imm_pkg::*;
(
    input  logic [31:0] value,
    output imm_class_t  cls
);

    logic fits_z13;
    logic fits_s13;
    logic fits_l26;

    // Field-fit tests. S13 needs bits 31..12 identical so that sign
    // extension of bit 12 reproduces the upper bits.
    always_comb begin
        fits_z13 = (value[31:SHORT_W] == '0);
        fits_s13 = (&value[31:SHORT_W-1]) || (value[31:SHORT_W-1] == '0);
        fits_l26 = (value[31:LONG_W] == '0);
    end

    // First matching field wins; the default is the HI beat of a split.
    always_comb begin
        cls.ctrl  = IMM_HI19;
        cls.split = 1'b1;
        cls.imm   = {{(LONG_W-HI_W){1'b0}}, value[31:SHORT_W]};
        if (fits_z13) begin
            cls.ctrl  = IMM_Z13;
            cls.split = 1'b0;
            cls.imm   = {{(LONG_W-SHORT_W){1'b0}}, value[SHORT_W-1:0]};
        end else if (fits_s13) begin
            cls.ctrl  = IMM_S13;
            cls.split = 1'b0;
            cls.imm   = {{(LONG_W-SHORT_W){1'b0}}, value[SHORT_W-1:0]};
        end else if (fits_l26) begin
            cls.ctrl  = IMM_L26;
            cls.split = 1'b0;
            cls.imm   = value[LONG_W-1:0];
        end
    end

endmodule

// File: rtl/imm_pack.sv
// Immediate packer: encodes a 32-bit constant into one immediate beat, or two
// beats (upper 19 bits, then lower 13 bits) when no single field fits.
// Optional build macro IMM_PACK_STATS_EN enables the split-encoding counter
// stat_split_cnt; without it the counter output is tied to zero.
//
// Handshake: on each side a transfer happens on a rising clk edge where
// valid && ready are both 1. A producer holding valid keeps its payload
// stable until the transfer; out_valid/imm/imm_ctrl/out_last here are
// registered and hold while out_ready is 0. in_ready depends only on the
// sequencer state and out_ready, never on in_valid.
module imm_pack
    import imm_pkg::*;
#(
    parameter int VALUE_W = 32,  // only 32 is supported
    parameter int STAT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VALUE_W-1:0] in_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LONG_W-1:0]  imm,
    output imm_ctrl_t          imm_ctrl,
    output logic               out_last,
    output logic [STAT_W-1:0]  stat_split_cnt,
    output pack_state_t        dbg_state
);

    pack_state_t        state_q, state_d;
    logic [LONG_W-1:0]  imm_q, imm_d;
    imm_ctrl_t          ctrl_q, ctrl_d;
    logic [SHORT_W-1:0] lo_q, lo_d;
    imm_class_t         cls;
    logic               accept;

    imm_classify u_classify (
        .value (in_value),
        .cls   (cls)
    );

    // Handshake and beat flags derived from the current state.
    always_comb begin
        out_valid = (state_q != ST_IDLE);
        out_last  = (state_q == ST_ONE) || (state_q == ST_LO);
        in_ready  = !out_valid || (out_ready && out_last);
        accept    = in_valid && in_ready;
    end

    // Next-state and next-beat selection.
    always_comb begin
        state_d = state_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        lo_d    = lo_q;
        // The low bits are captured on every accept; they are only
        // presented when the constant turns out to be a split.
        if (accept) begin
            lo_d = in_value[SHORT_W-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = cls.split ? ST_HI : ST_ONE;
                    imm_d   = cls.imm;
                    ctrl_d  = cls.ctrl;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    state_d = ST_LO;
                    imm_d   = {{(LONG_W-SHORT_W){1'b0}}, lo_q};
                    ctrl_d  = IMM_Z13;
                end
            end
            ST_ONE, ST_LO: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = cls.split ? ST_HI : ST_ONE;
                        imm_d   = cls.imm;
                        ctrl_d  = cls.ctrl;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and beat registers; reset discards any beat in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            imm_q   <= '0;
            ctrl_q  <= IMM_Z13;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            lo_q    <= lo_d;
        end
    end

    assign imm       = imm_q;
    assign imm_ctrl  = ctrl_q;
    assign dbg_state = state_q;

`ifdef IMM_PACK_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // Count accepted HI beats, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if ((state_q == ST_HI) && out_ready && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stat_split_cnt = stat_q;
`else
    assign stat_split_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_pack.sv
// Directed bench for imm_pack: a vector table of constants with hand-computed
// encodings, plus hand-written sequences for backpressure, back-to-back
// streaming, accept during LO and reset during a pending LO beat.
module tb_imm_pack;
    import imm_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_value;
    logic              out_valid;
    logic              out_ready;
    logic [25:0]       imm;
    imm_ctrl_t         imm_ctrl;
    logic              out_last;
    logic [15:0]       stat_split_cnt;
    pack_state_t       dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        logic        split;
        logic [1:0]  ctrl;
        logic [25:0] imm;
        logic [25:0] lo_imm;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    imm_pack dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_value       (in_value),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .imm            (imm),
        .imm_ctrl       (imm_ctrl),
        .out_last       (out_last),
        .stat_split_cnt (stat_split_cnt),
        .dbg_state      (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference expansion as ext_module performs it.
    function automatic logic [31:0] ext(input logic [1:0] ctrl, input logic [25:0] f);
        case (ctrl)
            2'b00:   return {19'b0, f[12:0]};
            2'b01:   return {{19{f[12]}}, f[12:0]};
            2'b10:   return {6'b0, f[25:0]};
            default: return {f[18:0], 13'b0};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] recon;

        vecs[0]  = '{32'h0000_0003, 1'b0, 2'b00, 26'h0000003, 26'h0};
        vecs[1]  = '{32'h0000_1000, 1'b0, 2'b00, 26'h0001000, 26'h0};
        vecs[2]  = '{32'hFFFF_FFFF, 1'b0, 2'b01, 26'h0001FFF, 26'h0};
        vecs[3]  = '{32'hFFFF_F000, 1'b0, 2'b01, 26'h0001000, 26'h0};
        vecs[4]  = '{32'h0200_0000, 1'b0, 2'b10, 26'h2000000, 26'h0};
        vecs[5]  = '{32'h03FF_FFFF, 1'b0, 2'b10, 26'h3FFFFFF, 26'h0};
        vecs[6]  = '{32'h0000_0000, 1'b0, 2'b00, 26'h0000000, 26'h0};
        vecs[7]  = '{32'h1234_5678, 1'b1, 2'b11, 26'h00091A2, 26'h1678};
        vecs[8]  = '{32'h0000_2000, 1'b0, 2'b10, 26'h0002000, 26'h0};
        vecs[9]  = '{32'hFFFF_EFFF, 1'b1, 2'b11, 26'h007FFFF, 26'h0FFF};
        vecs[10] = '{32'h0400_0000, 1'b1, 2'b11, 26'h0002000, 26'h0};
        vecs[11] = '{32'hFFFF_F800, 1'b0, 2'b01, 26'h0001800, 26'h0};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = '0;
        repeat (2) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_imm", imm, 0);
        chk("rst_ctrl", imm_ctrl, 0);
        chk("rst_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stat", stat_split_cnt, 0);
        rst_n = 1'b1;
        step();

        // Vector table
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_value = vecs[i].value;
            in_valid = 1'b1;
            chk("tbl_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            chk("tbl_b1_valid", out_valid, 1);
            chk("tbl_b1_ctrl", imm_ctrl, vecs[i].ctrl);
            chk("tbl_b1_imm", imm, vecs[i].imm);
            chk("tbl_b1_last", out_last, !vecs[i].split);
            recon = ext(imm_ctrl, imm);
            if (vecs[i].split) begin
                step();
                chk("tbl_b2_valid", out_valid, 1);
                chk("tbl_b2_ctrl", imm_ctrl, 2'b00);
                chk("tbl_b2_imm", imm, vecs[i].lo_imm);
                chk("tbl_b2_last", out_last, 1);
                recon = recon | ext(imm_ctrl, imm);
            end
            chk("tbl_recon", recon, vecs[i].value);
            step();
            chk("tbl_idle", out_valid, 0);
        end
`ifdef IMM_PACK_STATS_EN
        chk("stat_after_table", stat_split_cnt, 3);
`else
        chk("stat_tied_zero", stat_split_cnt, 0);
`endif

        // Backpressure during HI of 0x80000000
        out_ready = 1'b0;
        in_value  = 32'h8000_0000;
        in_valid  = 1'b1;
        step();
        in_value  = 32'h0000_0005;  // keep offering; must not be taken
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_ctrl", imm_ctrl, 2'b11);
            chk("bp_imm", imm, 26'h0040000);
            chk("bp_last", out_last, 0);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_lo_ctrl", imm_ctrl, 2'b00);
        chk("bp_lo_imm", imm, 0);
        chk("bp_lo_last", out_last, 1);
        step();
        chk("bp_idle", out_valid, 0);

        // Back-to-back single-field constants, one per cycle
        for (int k = 1; k <= 3; k++) begin
            in_value = k;
            in_valid = 1'b1;
            chk("b2b_in_ready", in_ready, 1);
            step();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_imm", imm, k);
            chk("b2b_last", out_last, 1);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_idle", out_valid, 0);

        // Split followed by a constant accepted during its LO beat
        in_value = 32'h1234_5678;
        in_valid = 1'b1;
        step();
        in_value = 32'h0000_0007;
        chk("lo_acc_hi_in_ready", in_ready, 0);
        chk("lo_acc_hi_imm", imm, 26'h00091A2);
        step();
        chk("lo_acc_lo_in_ready", in_ready, 1);
        chk("lo_acc_lo_imm", imm, 26'h0001678);
        step();
        in_valid = 1'b0;
        chk("lo_acc_next_ctrl", imm_ctrl, 2'b00);
        chk("lo_acc_next_imm", imm, 7);
        chk("lo_acc_next_last", out_last, 1);
        step();
        chk("lo_acc_idle", out_valid, 0);

        // Reset while LO of 0x12345678 is pending
        in_value = 32'h1234_5678;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("rlo_pre_last", out_last, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rlo_out_valid", out_valid, 0);
        chk("rlo_in_ready", in_ready, 1);
        chk("rlo_imm", imm, 0);
        chk("rlo_ctrl", imm_ctrl, 0);
        chk("rlo_last", out_last, 0);
        chk("rlo_stat", stat_split_cnt, 0);
        step();
        chk("rlo_stays_idle", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
